atm_ctrl: RTL and testbench

Parametrised ATM transaction controller: the next generation of the team's basic ATM FSM. It adds a withdrawal amount path, balance comparison, a PIN retry limit with card retention, a user cancel, and an inactivity timeout. It sits between the card/keypad front-end and the cash dispenser and account-debit logic.

---
 rtl/atm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_atm_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ctrl.sv
// ATM transaction controller: card session, PIN retry limit with card retention,
// amount/balance check, user cancel and inactivity timeout.
module atm_ctrl #(
    parameter int unsigned AMT_W         = 16,
    parameter int unsigned MAX_PIN_TRIES = 3,
    parameter int unsigned TIMEOUT_CYC   = 64,
    localparam int unsigned TRY_W        = $clog2(MAX_PIN_TRIES + 1),
    localparam int unsigned TMR_W        = $clog2(TIMEOUT_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_card_inserted,
    input  logic             i_pin_valid,
    input  logic             i_pin_correct,
    input  logic             i_amt_valid,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [AMT_W-1:0] i_balance,
    input  logic             i_cancel,
    output logic             o_dispense_cash,
    output logic [AMT_W-1:0] o_dispense_amt,
    output logic             o_debit_valid,
    output logic             o_card_eject,
    output logic             o_card_retain,
    output logic [1:0]       o_err_code,
    output logic [TRY_W-1:0] o_tries_left
);

    typedef enum logic [2:0] {
        StIdle,
        StCard,
        StPin,
        StAmount,
        StCheckBal,
        StDispense,
        StEject,
        StRetain
    } state_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrFunds   = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrLockout = 2'd3;

    state_e             r_state, w_state_d;
    logic               r_card_q;
    logic [AMT_W-1:0]   r_amt, w_amt_d;
    logic [TMR_W-1:0]   r_timer, w_timer_d;
    logic [TRY_W-1:0]   r_tries, w_tries_d;
    logic [1:0]         r_err, w_err_d;

    logic               w_start;
    logic               w_timeout;
    logic [TMR_W-1:0]   w_timer_inc;

    assign w_start     = i_card_inserted & ~r_card_q;
    assign w_timeout   = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
    // Saturating increment so the counter can never wrap back to zero.
    assign w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);

    always_comb begin
        w_state_d = r_state;
        w_amt_d   = r_amt;
        w_timer_d = r_timer;
        w_tries_d = r_tries;
        w_err_d   = r_err;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StCard;
                end
            end
            StCard: begin
                w_err_d   = ErrNone;
                w_tries_d = TRY_W'(MAX_PIN_TRIES);
                w_timer_d = '0;
                w_state_d = StPin;
            end
            StPin: begin
                // Any strobe, relevant or not, restarts the inactivity window.
                w_timer_d = (i_pin_valid | i_amt_valid) ? '0 : w_timer_inc;
                if (i_cancel) begin
                    w_state_d = StEject;
                end else if (i_pin_valid) begin
                    if (i_pin_correct) begin
                        w_state_d = StAmount;
                    end else begin
                        w_tries_d = r_tries - TRY_W'(1);
                        if (r_tries == TRY_W'(1)) begin
                            w_state_d = StRetain;
                            w_err_d   = ErrLockout;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_d = StEject;
                    w_err_d   = ErrTimeout;
                end
            end
            StAmount: begin
                w_timer_d = (i_pin_valid | i_amt_valid) ? '0 : w_timer_inc;
                if (i_cancel) begin
                    w_state_d = StEject;
                end else if (i_amt_valid) begin
                    w_amt_d = i_amt;
                    if (i_amt == '0) begin
                        w_state_d = StEject;
                        w_err_d   = ErrFunds;
                    end else begin
                        w_state_d = StCheckBal;
                    end
                end else if (w_timeout) begin
                    w_state_d = StEject;
                    w_err_d   = ErrTimeout;
                end
            end
            StCheckBal: begin
                if (r_amt <= i_balance) begin
                    w_state_d = StDispense;
                end else begin
                    w_state_d = StEject;
                    w_err_d   = ErrFunds;
                end
            end
            StDispense: begin
                w_state_d = StEject;
            end
            StEject: begin
                if (!i_card_inserted) begin
                    w_state_d = StIdle;
                end
            end
            StRetain: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_card_q <= 1'b0;
            r_amt    <= '0;
            r_timer  <= '0;
            r_tries  <= TRY_W'(MAX_PIN_TRIES);
            r_err    <= ErrNone;
        end else begin
            r_state  <= w_state_d;
            r_card_q <= i_card_inserted;
            r_amt    <= w_amt_d;
            r_timer  <= w_timer_d;
            r_tries  <= w_tries_d;
            r_err    <= w_err_d;
        end
    end

    assign o_dispense_cash = (r_state == StDispense);
    assign o_dispense_amt  = (r_state == StDispense) ? r_amt : '0;
    assign o_debit_valid   = (r_state == StDispense);
    assign o_card_eject    = (r_state == StEject);
    assign o_card_retain   = (r_state == StRetain);
    assign o_err_code      = r_err;
    assign o_tries_left    = r_tries;

endmodule

// File: tb/tb_atm_ctrl.sv
// Bench for atm_ctrl: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a session-level behavioural model.
module tb_atm_ctrl;
    localparam int unsigned AW = 16;
    localparam int unsigned MT = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned TW = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          card, pv, pc, av, cancel;
    logic [AW-1:0] amt, bal;
    logic          o_disp, o_debit, o_eject, o_retain;
    logic [AW-1:0] o_damt;
    logic [1:0]    o_err;
    logic [TW-1:0] o_tries;

    int  n_chk = 0;
    int  n_err = 0;
    bit  chk_en = 0;

    atm_ctrl #(.AMT_W(AW), .MAX_PIN_TRIES(MT), .TIMEOUT_CYC(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_card_inserted (card),
        .i_pin_valid     (pv),
        .i_pin_correct   (pc),
        .i_amt_valid     (av),
        .i_amt           (amt),
        .i_balance       (bal),
        .i_cancel        (cancel),
        .o_dispense_cash (o_disp),
        .o_dispense_amt  (o_damt),
        .o_debit_valid   (o_debit),
        .o_card_eject    (o_eject),
        .o_card_retain   (o_retain),
        .o_err_code      (o_err),
        .o_tries_left    (o_tries)
    );

    always #5 clk = ~clk;

    // Behavioural model: session phase plus idle-cycle counter, stepped on each rising edge.
    localparam int P_IDLE = 0, P_CARD = 1, P_PIN = 2, P_AMT = 3;
    localparam int P_CHK = 4, P_PAY = 5, P_OUT = 6, P_KEEP = 7;
    int            m_phase, m_tries, m_err, m_idle;
    logic [AW-1:0] m_amt;
    bit            m_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_tries = MT; m_err = 0; m_idle = 0; m_amt = '0; m_prev = 0;
        end else begin
            bit start;
            start  = card && !m_prev;
            m_prev = card;
            case (m_phase)
                P_IDLE: if (start) m_phase = P_CARD;
                P_CARD: begin m_err = 0; m_tries = MT; m_idle = 0; m_phase = P_PIN; end
                P_PIN: begin
                    if (cancel) m_phase = P_OUT;
                    else if (pv) begin
                        m_idle = 0;
                        if (pc) m_phase = P_AMT;
                        else begin
                            m_tries = m_tries - 1;
                            if (m_tries == 0) begin m_phase = P_KEEP; m_err = 3; end
                        end
                    end else if (m_idle == TO - 1) begin m_phase = P_OUT; m_err = 2; end
                    else m_idle = av ? 0 : m_idle + 1;
                end
                P_AMT: begin
                    if (cancel) m_phase = P_OUT;
                    else if (av) begin
                        m_idle = 0;
                        m_amt  = amt;
                        if (amt == 0) begin m_phase = P_OUT; m_err = 1; end
                        else m_phase = P_CHK;
                    end else if (m_idle == TO - 1) begin m_phase = P_OUT; m_err = 2; end
                    else m_idle = pv ? 0 : m_idle + 1;
                end
                P_CHK: begin
                    if (m_amt <= bal) m_phase = P_PAY;
                    else begin m_phase = P_OUT; m_err = 1; end
                end
                P_PAY:   m_phase = P_OUT;
                P_OUT:   if (!card) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic          e_disp, e_eject, e_retain;
            logic [AW-1:0] e_damt;
            e_disp   = (m_phase == P_PAY);
            e_damt   = e_disp ? m_amt : '0;
            e_eject  = (m_phase == P_OUT);
            e_retain = (m_phase == P_KEEP);
            n_chk++;
            if (o_disp !== e_disp || o_debit !== e_disp || o_damt !== e_damt ||
                o_eject !== e_eject || o_retain !== e_retain ||
                o_err !== 2'(m_err) || o_tries !== TW'(m_tries)) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got disp=%0b debit=%0b amt=%0d eject=%0b retain=%0b err=%0d tries=%0d want disp=%0b amt=%0d eject=%0b retain=%0b err=%0d tries=%0d",
                         $time, o_disp, o_debit, o_damt, o_eject, o_retain, o_err, o_tries,
                         e_disp, e_damt, e_eject, e_retain, m_err, m_tries);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_session();
        card = 0; tick(); card = 1; tick(2);
        check("tries_at_pin", int'(o_tries), MT);
    endtask

    task automatic session(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input bit exp_disp, input int exp_err);
        open_session();
        pv = 1; pc = 1; tick(); pv = 0;
        av = 1; amt = a; tick(); av = 0; bal = b;
        if (a == 0) begin
            check("zero_amt_eject", int'(o_eject), 1);
        end else begin
            tick();
            check("disp_cash", int'(o_disp), int'(exp_disp));
            check("disp_amt", int'(o_damt), exp_disp ? int'(a) : 0);
            check("debit_valid", int'(o_debit), int'(exp_disp));
            tick();
            check("eject_after", int'(o_eject), 1);
        end
        check("session_err", int'(o_err), exp_err);
        tick();
        check("eject_held", int'(o_eject), 1);
        card = 0; tick();
        check("eject_released", int'(o_eject), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        rst = 1; card = 0; pv = 0; pc = 0; av = 0; cancel = 0; amt = '0; bal = '0;
        tick(2);
        rst = 0; chk_en = 1;
        check("rst_tries", int'(o_tries), MT);
        check("rst_err", int'(o_err), 0);
        check("rst_eject", int'(o_eject), 0);

        session(16'd100, 16'd500, 1'b1, 0);
        session(16'd600, 16'd500, 1'b0, 1);
        session(16'd0,   16'd500, 1'b0, 1);
        session(16'd500, 16'd500, 1'b1, 0);

        // PIN lockout, then card held high must not restart.
        open_session();
        pv = 1; pc = 0; tick();
        check("lock_tries2", int'(o_tries), 2);
        tick();
        check("lock_tries1", int'(o_tries), 1);
        tick(); pv = 0;
        check("lock_tries0", int'(o_tries), 0);
        check("lock_retain", int'(o_retain), 1);
        check("lock_err", int'(o_err), 3);
        tick();
        check("retain_pulse", int'(o_retain), 0);
        tick(4);
        check("no_restart_tries", int'(o_tries), 0);
        check("no_restart_eject", int'(o_eject), 0);

        // Timeout exactly TO cycles after PIN entry.
        open_session();
        tick(TO - 1);
        check("to_not_yet", int'(o_eject), 0);
        tick();
        check("to_eject", int'(o_eject), 1);
        check("to_err", int'(o_err), 2);

        // Wrong-PIN strobe on the last idle cycle wins and restarts the window.
        open_session();
        tick(TO - 1);
        pv = 1; pc = 0; tick(); pv = 0;
        check("to_strobe_stay", int'(o_eject), 0);
        check("to_strobe_tries", int'(o_tries), 2);
        tick(TO - 1);
        check("to2_not_yet", int'(o_eject), 0);
        tick();
        check("to2_eject", int'(o_eject), 1);

        // Cancel beats a simultaneous wrong PIN.
        open_session();
        cancel = 1; pv = 1; pc = 0; tick(); cancel = 0; pv = 0;
        check("cancel_eject", int'(o_eject), 1);
        check("cancel_tries", int'(o_tries), MT);
        check("cancel_err", int'(o_err), 0);

        // Async reset while in CHECK_BAL.
        open_session();
        pv = 1; pc = 1; tick(); pv = 0;
        av = 1; amt = 16'd100; tick(); av = 0; bal = 16'd500;
        #2 rst = 1; card = 0;
        #1;
        check("arst_disp", int'(o_disp), 0);
        check("arst_eject", int'(o_eject), 0);
        check("arst_tries", int'(o_tries), MT);
        tick(); rst = 0; tick();
        check("arst_no_disp", int'(o_disp), 0);

        // Randomized traffic, checked by the model every cycle.
        quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) card = ~card;
            cancel = !quiet && ($urandom_range(0, 39) == 0);
            pv     = !quiet && ($urandom_range(0, 4) == 0);
            pc     = ($urandom_range(0, 2) != 0);
            av     = !quiet && ($urandom_range(0, 4) == 0);
            amt    = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 1000));
            bal    = AW'($urandom_range(0, 1000));
            tick();
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
